bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
- Parameters:
  - REQ-001 TMO, default 16, access timeout in cycles; legal range 1..255.
- Ports (clock and reset first):
  - REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
  - REQ-003 RES  input  1  asynchronous, active-low reset.
  - REQ-004 REQ  input  4  per-requester access request; bit i = requester i.
  - REQ-005 WE  input  4  per-requester direction: 1 write, 0 read; valid while REQ[i].
  - REQ-006 ADDR  input  64  requester i address at [16i+15:16i].
  - REQ-007 WDATA  input  64  requester i write data at [16i+15:16i].
  - REQ-008 ACK  output  4  one-cycle completion pulse to the granted requester.
  - REQ-009 ERR  output  1  high with ACK when the access timed out.
  - REQ-010 RDATA  output  16  read data; valid while any ACK bit is high.
  - REQ-011 M_RD  output  1  shared-port read strobe.
  - REQ-012 M_WR  output  1  shared-port write strobe.
  - REQ-013 M_ADDR  output  16  shared-port address.
  - REQ-014 M_WDATA  output  16  shared-port write data.
  - REQ-015 M_RDATA  input  16  shared-port read data; sampled when M_RDY is high.
  - REQ-016 M_RDY  input  1  shared-port completion; sampled only in ACCESS.

Function
- REQ-017 The block SHALL serialise four requesters onto one shared port using a three-state FSM: IDLE, ACCESS, DONE.
- REQ-018 All outputs SHALL be registered; none SHALL depend combinationally on any input.
- REQ-019 IDLE, REQ==0: the FSM SHALL remain in IDLE with M_RD=M_WR=0.
- REQ-020 IDLE, REQ!=0: the FSM SHALL grant the first set bit scanning from (LAST+1) mod 4 upward with wrap-around.
  - On that edge it SHALL latch grant index G, M_ADDR, M_WDATA and WE[G], and assert M_RD (WE=0) or M_WR (WE=1).
  - It SHALL then enter ACCESS and clear the timeout counter CNT.
- REQ-021 ACCESS, M_RDY=1 at an edge: the FSM SHALL deassert M_RD/M_WR, set ACK[G]=1 and ERR=0, and enter DONE.
  - On a read it SHALL capture M_RDATA into RDATA.
  - On a write, RDATA SHALL hold its previous value.
- REQ-022 ACCESS, M_RDY=0 and CNT==TMO-1: the FSM SHALL deassert the strobe, set ACK[G]=1 and ERR=1, and enter DONE.
  - On a read it SHALL load RDATA=16'hFFFF.
- REQ-023 ACCESS, M_RDY=0 and CNT<TMO-1: the FSM SHALL increment CNT (8-bit, never wraps) and hold all M_* outputs stable.
- REQ-024 If M_RDY=1 on the same edge CNT==TMO-1, success SHALL take priority (ERR=0).
- REQ-025 DONE SHALL last exactly one cycle with ACK[G] high.
  - On exit the FSM SHALL set LAST=G, clear ACK and ERR, and return to IDLE.
  - No grant SHALL be issued in DONE.
- REQ-026 At most one ACK bit SHALL be high in any cycle, and M_RD and M_WR SHALL never be high together.
- REQ-027 Latency: REQ sampled in IDLE at edge k gives a strobe after edge k; with M_RDY=1 at edge k+1, ACK is high from edge k+1 to edge k+2.
  - Minimum issue interval SHALL be 3 cycles.
- REQ-028 A requester that drops REQ during ACCESS SHALL NOT abort the access; ACK SHALL still pulse.
- REQ-029 Changes to ADDR/WDATA/WE after grant SHALL NOT affect the access in flight.

Reset
- REQ-030 RES low SHALL immediately, without waiting for CLK, force all of the following:
  - FSM=IDLE, G=0, LAST=3, CNT=0;
  - ACK=0, ERR=0, RDATA=0;
  - M_RD=0, M_WR=0, M_ADDR=0, M_WDATA=0.
- REQ-031 Reset asserted mid-ACCESS or mid-DONE SHALL abandon the transfer with no ACK issued.
  - The first grant after reset release SHALL favour requester 0.

Verification
- REQ-032 Single read: REQ=0001, WE=0, ADDR0=16'h0010, M_RDY=1 one cycle after strobe, M_RDATA=16'h0ABC -> M_RD one cycle, M_ADDR=16'h0010, ACK=0001 one cycle, RDATA=16'h0ABC, ERR=0.
- REQ-033 Round-robin: REQ=1111 held, each requester de-asserting after its ACK, M_RDY always 1 -> grant order 0,1,2,3; ACK pulses 3 cycles apart.
- REQ-034 Fairness: REQ=0101 held continuously -> grants alternate 0,2,0,2; requester 1 and requester 3 never acknowledged.
- REQ-035 Timeout: TMO=4, requester 2 read, M_RDY=0 -> strobe high exactly 4 cycles, ACK=0100 with ERR=1, RDATA=16'hFFFF; repeat with M_RDY=1 on the 4th cycle -> ERR=0.
- REQ-036 Reset mid-access: requester 3 write in ACCESS, RES pulsed low -> M_WR=0, ACK=0 immediately with no clock edge; next REQ=1001 -> requester 0 granted first.

Source files
------------

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter serialising four requesters onto one shared port
module bus_arbiter #(
  parameter int TMO = 16
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [3:0]  REQ,
  input  logic [3:0]  WE,
  input  logic [63:0] ADDR,
  input  logic [63:0] WDATA,
  output logic [3:0]  ACK,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic        M_RD,
  output logic        M_WR,
  output logic [15:0] M_ADDR,
  output logic [15:0] M_WDATA,
  input  logic [15:0] M_RDATA,
  input  logic        M_RDY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Last cycle of the timeout window; CNT starts at 0 on entry to ACCESS.
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t     state;
  logic [1:0] g;
  logic [1:0] last;
  logic [7:0] cnt;
  logic       we_l;

  logic       found;
  logic [1:0] pick;
  logic [1:0] idx;

  // Round-robin pick: first requesting index scanning upward from last+1, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && REQ[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state   <= IDLE;
      g       <= 2'd0;
      last    <= 2'd3;
      cnt     <= 8'd0;
      we_l    <= 1'b0;
      ACK     <= 4'b0000;
      ERR     <= 1'b0;
      RDATA   <= 16'h0000;
      M_RD    <= 1'b0;
      M_WR    <= 1'b0;
      M_ADDR  <= 16'h0000;
      M_WDATA <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            g       <= pick;
            we_l    <= WE[pick];
            M_ADDR  <= ADDR[{pick, 4'b0000} +: 16];
            M_WDATA <= WDATA[{pick, 4'b0000} +: 16];
            M_RD    <= ~WE[pick];
            M_WR    <= WE[pick];
            cnt     <= 8'd0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          // Completion wins over timeout when both land on the same edge.
          if (M_RDY) begin
            M_RD  <= 1'b0;
            M_WR  <= 1'b0;
            ACK   <= 4'(4'b0001 << g);
            ERR   <= 1'b0;
            if (!we_l) RDATA <= M_RDATA;
            state <= DONE;
          end else if (cnt == TMO_LAST) begin
            M_RD  <= 1'b0;
            M_WR  <= 1'b0;
            ACK   <= 4'(4'b0001 << g);
            ERR   <= 1'b1;
            if (!we_l) RDATA <= 16'hFFFF;
            state <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          last  <= g;
          ACK   <= 4'b0000;
          ERR   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
